// File: rtl/acc_8bit_pkg.sv
// Shared widths, limits and types for the acc_8bit accumulator.
package acc_8bit_pkg;

    localparam int ACC_IN_W = 8;
    localparam int ACC_W    = 16;

    typedef logic [ACC_IN_W-1:0] acc_in_t;
    typedef logic [ACC_W-1:0]    acc_t;

    localparam acc_t ACC_MAX = 16'hFFFF;

    // Zero-extend an addend to the accumulator width.
    function automatic acc_t acc_zext(input acc_in_t value);
        return {{(ACC_W - ACC_IN_W){1'b0}}, value};
    endfunction

endpackage

// File: rtl/acc_8bit_add16.sv
// 16-bit combinational ripple-carry adder built from per-bit full adders.
// Exposes the carry out of bit 15 so the parent can choose wrap or saturate.
module acc_8bit_add16
    import acc_8bit_pkg::*;
(
    input  acc_t a,
    input  acc_t b,
    output acc_t sum,
    output logic carry_out
);

    logic carry;

    // Ripple the carry through one full adder per bit, LSB first.
    always_comb begin
        // NOTE: every output gets a value before the loop so no path leaves
        // one unassigned (which would infer a latch); blocking '=' is used
        // here because each bit needs the carry produced by the bit below it
        // within the same evaluation.
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < ACC_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
        carry_out = carry;
    end

endmodule

// File: rtl/acc_8bit.sv
// acc_8bit: adds an unsigned 8-bit input into a 16-bit running sum on each
// enabled clock edge. Synchronous clear via i_init (priority over i_enable),
// asynchronous clear via i_rst_n. o_acc is driven straight from the register.
//
// Build option: define ACC_8BIT_SAT_EN for a saturating add (sticks at
// 16'hFFFF on overflow); otherwise the sum wraps modulo 2^16.
module acc_8bit
    import acc_8bit_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_init,
    input  logic [7:0]  i_in,
    output logic [15:0] o_acc
);

    acc_t acc;
    acc_t add_sum;
    acc_t add_result;
    logic add_carry;

    acc_8bit_add16 u_add16 (
        .a         (acc),
        .b         (acc_zext(i_in)),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

`ifdef ACC_8BIT_SAT_EN
    // Clamp to full scale when the add carries out of bit 15.
    assign add_result = add_carry ? ACC_MAX : add_sum;
`else
    // Wrap modulo 2^16: the carry is intentionally discarded.
    logic carry_unused;
    assign carry_unused = add_carry;
    assign add_result   = add_sum;
`endif

    // Accumulator register: async clear, then sync clear, then enabled add.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: non-blocking '<=' for register state so every flop samples
        // the pre-edge values, independent of statement order.
        if (!i_rst_n) begin
            acc <= '0;
        end else if (i_init) begin
            acc <= '0;
        end else if (i_enable) begin
            acc <= add_result;
        end
    end

    assign o_acc = acc;

endmodule

// File: tb/tb_acc_8bit.sv
// Scoreboard bench for acc_8bit: the driver pushes hand-computed expected
// sums into a queue; an independent monitor pops and compares them just after
// each rising edge, or just after an asynchronous reset pulse.
module tb_acc_8bit;
    import acc_8bit_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_enable;
    logic        i_init;
    logic [7:0]  i_in;
    logic [15:0] o_acc;

    typedef struct {
        string name;
        acc_t  exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    event async_ev;

    acc_8bit dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (i_enable),
        .i_init   (i_init),
        .i_in     (i_in),
        .o_acc    (o_acc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Monitor: compare the oldest expectation 1 ns after each event.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk or async_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (o_acc !== e.exp) begin
                    errors++;
                    $display("FAIL %s: o_acc=%h expected=%h at %0t", e.name, o_acc, e.exp, $time);
                end
            end
        end
    end

    function automatic void push(input string name, input acc_t exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
    endfunction

    // Apply inputs at the falling edge; optionally expect a value after the next rising edge.
    task automatic drive(input logic rst_n, input logic init, input logic en,
                         input logic [7:0] din, input bit chk, input string name,
                         input acc_t exp);
        @(negedge i_clk);
        i_rst_n  = rst_n;
        i_init   = init;
        i_enable = en;
        i_in     = din;
        if (chk) push(name, exp);
    endtask

    acc_t ramp_exp [10] = '{16'd1, 16'd3, 16'd6, 16'd10, 16'd15,
                            16'd21, 16'd28, 16'd36, 16'd45, 16'd55};

    initial begin
        checks   = 0;
        errors   = 0;
        i_rst_n  = 1'b0;
        i_init   = 1'b0;
        i_enable = 1'b1;
        i_in     = 8'hFF;

        // Reset held with enable and full-scale input: stays 0.
        drive(0, 0, 1, 8'hFF, 1, "reset_hold0", 16'h0000);
        drive(0, 0, 1, 8'hFF, 1, "reset_hold1", 16'h0000);
        // Release with no enables: stays 0.
        drive(1, 0, 0, 8'hFF, 1, "post_reset0", 16'h0000);
        drive(1, 0, 0, 8'h5A, 1, "post_reset1", 16'h0000);

        // Ramp 1..10 after an init pulse.
        drive(1, 1, 0, 8'h00, 1, "init_pulse", 16'h0000);
        for (int k = 0; k < 10; k++)
            drive(1, 0, 1, 8'(k + 1), 1, $sformatf("ramp%0d", k + 1), ramp_exp[k]);
        drive(1, 0, 0, 8'h33, 1, "ramp_hold0", 16'd55);
        drive(1, 0, 0, 8'h44, 1, "ramp_hold1", 16'd55);

        // Init beats enable; the addend is lost.
        drive(1, 1, 1, 8'd7, 1, "init_priority", 16'h0000);

        // Overflow: 255 added 257 times reaches FFFF.
        for (int n = 1; n <= 257; n++) begin
            case (n)
                1:       drive(1, 0, 1, 8'hFF, 1, "ovf_n1",   16'h00FF);
                256:     drive(1, 0, 1, 8'hFF, 1, "ovf_n256", 16'hFF00);
                257:     drive(1, 0, 1, 8'hFF, 1, "ovf_n257", 16'hFFFF);
                default: drive(1, 0, 1, 8'hFF, 0, "", '0);
            endcase
        end
`ifdef ACC_8BIT_SAT_EN
        drive(1, 0, 1, 8'hFF, 1, "ovf_sat0", 16'hFFFF);
        drive(1, 0, 1, 8'hFF, 1, "ovf_sat1", 16'hFFFF);
`else
        drive(1, 0, 1, 8'hFF, 1, "ovf_wrap0", 16'h00FE);
        drive(1, 0, 1, 8'hFF, 1, "ovf_wrap1", 16'h01FD);
`endif
        drive(1, 1, 0, 8'h00, 1, "ovf_init", 16'h0000);

        // Async reset between edges while accumulating.
        drive(1, 0, 1, 8'd3, 1, "run0", 16'd3);
        drive(1, 0, 1, 8'd3, 1, "run1", 16'd6);
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        push("async_clear", 16'h0000);
        ->async_ev;
        drive(0, 0, 1, 8'd3, 1, "async_held", 16'h0000);
        drive(1, 0, 1, 8'd4, 1, "resume0", 16'd4);
        drive(1, 0, 1, 8'd5, 1, "resume1", 16'd9);
        drive(1, 0, 1, 8'd0, 1, "add_zero", 16'd9);

        // Hold with random inputs.
        for (int h = 0; h < 20; h++)
            drive(1, 0, 0, 8'($urandom_range(255)), 1, $sformatf("hold%0d", h), 16'd9);

        // Drain the scoreboard within a bounded number of cycles.
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge i_clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
